preamble_sfd_tx: RTL and testbench

PREAMBLE_SFD_TX -- requirements
Module: preamble_sfd_tx

---
 rtl/preamble_sfd_tx_pkg.sv | 23 ++
 rtl/preamble_sfd_tx_if.sv | 42 ++++
 rtl/preamble_sfd_tx.sv | 95 +++++++++
 tb/tb_preamble_sfd_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preamble_sfd_tx_pkg.sv
// Shared Ethernet TX definitions: FSM state encoding, framing bytes and
// default lengths for the preamble/SFD inserter.
package preamble_sfd_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        PAYLOAD,
        FCS,
        IFG
    } tx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam int unsigned PREAMBLE_LEN_DEFAULT = 7;
    localparam int unsigned IFG_LEN_DEFAULT      = 12;

    // One counter is shared by PREAMBLE and IFG, so both lengths must fit in it.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/preamble_sfd_tx_if.sv
// Frame handshake and GMII pin bundle between the protocol arbiter/builders
// and the preamble/SFD inserter.
interface preamble_sfd_tx_if;

    logic        tx_req;
    logic        tx_ready;
    logic [7:0]  payload_data;
    logic        payload_done;
    logic [7:0]  fcs_data;
    logic        fcs_tx_done;
    logic        preamble_sfd_tx_done;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic [15:0] tx_frame_cnt;

    modport master (
        output tx_req,
        output payload_data,
        output payload_done,
        output fcs_data,
        output fcs_tx_done,
        input  tx_ready,
        input  preamble_sfd_tx_done,
        input  gmii_txd,
        input  gmii_tx_en,
        input  tx_frame_cnt
    );

    modport slave (
        input  tx_req,
        input  payload_data,
        input  payload_done,
        input  fcs_data,
        input  fcs_tx_done,
        output tx_ready,
        output preamble_sfd_tx_done,
        output gmii_txd,
        output gmii_tx_en,
        output tx_frame_cnt
    );

endinterface

// File: rtl/preamble_sfd_tx.sv
// Ethernet frame sequencer: prepends preamble + SFD, passes payload and FCS
// bytes through, then enforces the inter-frame gap. GMII pins are registered.
module preamble_sfd_tx
    import preamble_sfd_tx_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = PREAMBLE_LEN_DEFAULT,
    parameter int unsigned IFG_LEN      = IFG_LEN_DEFAULT
) (
    input  logic              aclk,
    input  logic              aresetn,
    preamble_sfd_tx_if.slave  bus
);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_LEN - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      frame_cnt;
    logic [7:0]       txd_q;
    logic             tx_en_q;

    logic [7:0]       tx_byte;
    logic             active;

    always_comb begin
        tx_byte = 8'h00;
        active  = 1'b0;
        case (state)
            PREAMBLE: begin tx_byte = PREAMBLE_BYTE;    active = 1'b1; end
            SFD:      begin tx_byte = SFD_BYTE;         active = 1'b1; end
            PAYLOAD:  begin tx_byte = bus.payload_data; active = 1'b1; end
            FCS:      begin tx_byte = bus.fcs_data;     active = 1'b1; end
            default:  begin tx_byte = 8'h00;            active = 1'b0; end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_cnt <= '0;
            txd_q     <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            txd_q   <= tx_byte;
            tx_en_q <= active;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.tx_req) state <= PREAMBLE;
                end
                PREAMBLE: begin
                    if (cnt == PRE_LAST) begin
                        cnt   <= '0;
                        state <= SFD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // payload_done is not looked at here, so PAYLOAD lasts at least one byte
                SFD: state <= PAYLOAD;
                PAYLOAD: begin
                    if (bus.payload_done) state <= FCS;
                end
                FCS: begin
                    if (bus.fcs_tx_done) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        cnt       <= '0;
                        state     <= IFG;
                    end
                end
                IFG: begin
                    if (cnt == IFG_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready             = (state == IDLE);
    assign bus.preamble_sfd_tx_done = (state == SFD);
    assign bus.gmii_txd             = txd_q;
    assign bus.gmii_tx_en           = tx_en_q;
    assign bus.tx_frame_cnt         = frame_cnt;

endmodule

// File: tb/tb_preamble_sfd_tx.sv
// Bench for preamble_sfd_tx: drives frames with random contents and compares
// the recorded GMII wire trace against frames assembled from the framing rules.
module tb_preamble_sfd_tx;

    localparam int unsigned PRE_N = 7;
    localparam int unsigned IFG_N = 12;

    logic aclk = 1'b0;
    logic aresetn;

    preamble_sfd_tx_if bus();

    preamble_sfd_tx #(.PREAMBLE_LEN(PRE_N), .IFG_LEN(IFG_N)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    logic [8:0]  wire_q[$];
    int          done_idx[$];
    logic [7:0]  exp_bytes[$];
    int          exp_len[$];
    logic [7:0]  got_bytes[$];
    int          got_len[$];
    int          got_gap[$];
    int          bad_idle;
    logic [7:0]  pl_q[$];
    logic [7:0]  fc_q[$];
    logic [15:0] exp_cnt;

    // Wire recorder: one {tx_en, txd} sample per cycle, plus where the SFD strobe fired.
    always @(posedge aclk) begin
        #1;
        if (bus.preamble_sfd_tx_done) done_idx.push_back(wire_q.size());
        wire_q.push_back({bus.gmii_tx_en, bus.gmii_txd});
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic junk();
        bus.payload_done = 1'($urandom_range(0, 1));
        bus.fcs_tx_done  = 1'($urandom_range(0, 1));
        bus.payload_data = 8'($urandom);
        bus.fcs_data     = 8'($urandom);
    endtask

    task automatic rand_frame(input int n);
        pl_q.delete();
        fc_q.delete();
        repeat (n) pl_q.push_back(8'($urandom));
        repeat (4) fc_q.push_back(8'($urandom));
    endtask

    task automatic idle(input int n, input int poke_at);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            junk();
            bus.tx_req = (i == poke_at);
        end
        bus.tx_req = 1'b0;
    endtask

    task automatic send_frame(input bit hold, input bit poke);
        int k;
        bus.tx_req = 1'b1;
        k = 0;
        while (!bus.tx_ready && k < 100) begin
            @(negedge aclk);
            junk();
            k++;
        end
        chk("accept_wait", 32'(bus.tx_ready), 32'h1);
        @(negedge aclk);
        bus.tx_req = hold;
        k = 0;
        while (!bus.preamble_sfd_tx_done && k < 40) begin
            @(negedge aclk);
            junk();
            k++;
        end
        chk("sfd_wait", 32'(bus.preamble_sfd_tx_done), 32'h1);
        for (int i = 0; i < pl_q.size(); i++) begin
            @(negedge aclk);
            junk();
            bus.tx_req       = hold || (poke && i == 0);
            bus.payload_data = pl_q[i];
            bus.payload_done = (i == pl_q.size() - 1);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge aclk);
            junk();
            bus.tx_req      = hold;
            bus.fcs_data    = fc_q[j];
            bus.fcs_tx_done = (j == 3);
        end
        @(negedge aclk);
        junk();
        exp_cnt = exp_cnt + 16'd1;
        chk("frame_cnt", 32'(bus.tx_frame_cnt), 32'(exp_cnt));
        exp_len.push_back(int'(PRE_N) + 1 + pl_q.size() + 4);
        repeat (PRE_N) exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'hD5);
        foreach (pl_q[i]) exp_bytes.push_back(pl_q[i]);
        foreach (fc_q[i]) exp_bytes.push_back(fc_q[i]);
    endtask

    task automatic parse();
        int run;
        int gap;
        bit seen;
        run = 0;
        gap = 0;
        seen = 1'b0;
        bad_idle = 0;
        got_bytes.delete();
        got_len.delete();
        got_gap.delete();
        foreach (wire_q[i]) begin
            if (wire_q[i][8]) begin
                if (run == 0 && seen) got_gap.push_back(gap);
                run++;
                got_bytes.push_back(wire_q[i][7:0]);
            end else begin
                if (wire_q[i][7:0] != 8'h00) bad_idle++;
                if (run > 0) begin
                    got_len.push_back(run);
                    run = 0;
                    seen = 1'b1;
                    gap = 0;
                end
                gap++;
            end
        end
        if (run > 0) got_len.push_back(run);
    endtask

    task automatic check_wire(input string tag);
        int n;
        int idx;
        logic [31:0] s;
        parse();
        chk({tag, "_nframes"}, 32'(got_len.size()), 32'(exp_len.size()));
        n = (got_len.size() < exp_len.size()) ? got_len.size() : exp_len.size();
        for (int i = 0; i < n; i++) chk({tag, "_len"}, 32'(got_len[i]), 32'(exp_len[i]));
        n = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(got_bytes[i]), 32'(exp_bytes[i]));
        chk({tag, "_idle_zero"}, 32'(bad_idle), 32'h0);
        chk({tag, "_sfd_pulses"}, 32'(done_idx.size()), 32'(exp_len.size()));
        foreach (done_idx[i]) begin
            idx = done_idx[i];
            s = (idx + 1 < wire_q.size()) ? 32'(wire_q[idx + 1]) : 32'h0;
            chk({tag, "_d5_after_pulse"}, s, 32'h1D5);
            chk({tag, "_55_at_pulse"}, 32'(wire_q[idx]), 32'h155);
        end
        exp_bytes.delete();
        exp_len.delete();
        wire_q.delete();
        done_idx.delete();
    endtask

    initial begin
        aresetn          = 1'b0;
        bus.tx_req       = 1'b0;
        bus.payload_data = 8'h00;
        bus.payload_done = 1'b0;
        bus.fcs_data     = 8'h00;
        bus.fcs_tx_done  = 1'b0;
        exp_cnt          = 16'h0000;

        // Reset state
        #1;
        chk("rst_tx_en", 32'(bus.gmii_tx_en), 32'h0);
        chk("rst_txd", 32'(bus.gmii_txd), 32'h0);
        chk("rst_cnt", 32'(bus.tx_frame_cnt), 32'h0);
        chk("rst_done", 32'(bus.preamble_sfd_tx_done), 32'h0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("ready_idle", 32'(bus.tx_ready), 32'h1);

        // Directed frame: payload A1..A3, FCS F0..F3
        pl_q = '{8'hA1, 8'hA2, 8'hA3};
        fc_q = '{8'hF0, 8'hF1, 8'hF2, 8'hF3};
        send_frame(1'b0, 1'b0);
        idle(20, -1);
        check_wire("directed");

        // Randomized single frames with random idle spacing
        for (int f = 0; f < 4; f++) begin
            rand_frame(int'($urandom_range(1, 8)));
            send_frame(1'b0, 1'b0);
            idle(int'($urandom_range(0, 5)), -1);
        end
        idle(20, -1);
        check_wire("random");
        foreach (got_gap[i]) chk("random_gap_min", 32'(got_gap[i] >= 13), 32'h1);

        // tx_req held high: back-to-back frames separated by IFG+1 idle cycles
        bus.tx_req = 1'b1;
        for (int f = 0; f < 3; f++) begin
            rand_frame(int'($urandom_range(1, 6)));
            send_frame(1'b1, 1'b0);
        end
        bus.tx_req = 1'b0;
        idle(20, -1);
        check_wire("b2b");
        chk("b2b_gap_count", 32'(got_gap.size()), 32'h2);
        foreach (got_gap[i]) chk("b2b_gap", 32'(got_gap[i]), 32'd13);

        // tx_req pulses during PAYLOAD and IFG are dropped
        rand_frame(int'($urandom_range(2, 6)));
        send_frame(1'b0, 1'b1);
        idle(30, 3);
        idle(10, -1);
        check_wire("ignored_req");

        // Reset during the third preamble byte truncates the frame
        @(negedge aclk);
        bus.tx_req = 1'b1;
        @(negedge aclk);
        bus.tx_req = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        chk("mid_pre_tx_en", 32'(bus.gmii_tx_en), 32'h1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_rst_tx_en", 32'(bus.gmii_tx_en), 32'h0);
        chk("async_rst_txd", 32'(bus.gmii_txd), 32'h0);
        chk("async_rst_ready", 32'(bus.tx_ready), 32'h1);
        chk("async_rst_done", 32'(bus.preamble_sfd_tx_done), 32'h0);
        chk("async_rst_cnt", 32'(bus.tx_frame_cnt), 32'h0);
        exp_cnt = 16'h0000;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("ready_after_rst", 32'(bus.tx_ready), 32'h1);
        @(negedge aclk);
        wire_q.delete();
        done_idx.delete();
        rand_frame(int'($urandom_range(1, 4)));
        send_frame(1'b0, 1'b0);
        idle(20, -1);
        check_wire("post_reset");

        // Frame counter wrap from 0xFFFF
        @(negedge aclk);
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        exp_cnt = 16'hFFFF;
        rand_frame(1);
        send_frame(1'b0, 1'b0);
        chk("cnt_wrap", 32'(bus.tx_frame_cnt), 32'h0);
        idle(20, -1);
        check_wire("wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
